mac_datapath: RTL and testbench

MAC_DATAPATH -- requirements
Module: mac_datapath

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_acc.sv | 92 +++++++++
 rtl/mac_datapath.sv | 69 ++++++
 tb/tb_mac_datapath.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults and width types for the multiply-accumulate datapath.
package mac_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ACC_W_DEF   = 20;
    localparam int unsigned N_TERMS_DEF = 4;

    typedef logic [DATA_W_DEF-1:0]   operand_t;
    typedef logic [2*DATA_W_DEF-1:0] product_t;
    typedef logic [ACC_W_DEF-1:0]    acc_t;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mac_acc.sv
// Accumulator, term counter and sticky done/overflow flags.
// MAC_SATURATE_EN defined: overflowing accumulates clamp to all ones; otherwise they wrap.
module mac_acc
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W  = 2 * DATA_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [PROD_W-1:0]                  product_i,
    input  logic                               sum_ld_i,
    input  logic                               sum_clr_i,
    output logic [ACC_W-1:0]                   sum_o,
    output logic                               sum_valid_o,
    output logic [$clog2(N_TERMS+1)-1:0]       term_cnt_o,
    output logic                               done_o,
    output logic                               ovf_o
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    // One spare bit above the wider of accumulator and product catches every carry.
    localparam int unsigned EXT_W = max_w(ACC_W, PROD_W) + 1;

    logic [ACC_W-1:0] sum_d, sum_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             valid_d, valid_q;
    logic             done_d, done_q;
    logic             ovf_d, ovf_q;
    logic [EXT_W-1:0] sum_ext_s;
    logic             overflow_s;
    logic             accept_s;

    // Next-state logic: clear beats accumulate; accumulate is ignored once done.
    always_comb begin
        sum_ext_s  = EXT_W'(sum_q) + EXT_W'(product_i);
        overflow_s = (sum_ext_s[EXT_W-1:ACC_W] != {(EXT_W-ACC_W){1'b0}});
        accept_s   = sum_ld_i && !done_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        done_d     = done_q;
        ovf_d      = ovf_q;
        if (sum_clr_i) begin
            sum_d  = {ACC_W{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (accept_s) begin
            if (overflow_s) begin
                ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
                sum_d = {ACC_W{1'b1}};
`else
                sum_d = sum_ext_s[ACC_W-1:0];
`endif
            end else begin
                sum_d = sum_ext_s[ACC_W-1:0];
            end
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b1;
            done_d  = (cnt_d == CNT_W'(N_TERMS));
        end else begin
            valid_d = 1'b0;
        end
    end

    // Accumulator state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = valid_q;
    assign term_cnt_o  = cnt_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/mac_datapath.sv
// Operand registers and multiplier feeding the mac_acc accumulator.
// Overflow handling is selected in mac_acc by MAC_SATURATE_EN.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              x_in,
    input  logic [DATA_W-1:0]              y_in,
    input  logic                           x_ld,
    input  logic                           y_ld,
    input  logic                           sum_ld,
    input  logic                           sum_clr,
    input  logic                           mult_sel,
    output logic [ACC_W-1:0]               sum,
    output logic                           sum_valid,
    output logic [$clog2(N_TERMS+1)-1:0]   term_cnt,
    output logic                           done,
    output logic                           ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] x_d, x_q;
    logic [DATA_W-1:0] y_d, y_q;
    logic [DATA_W-1:0] operand_b_s;
    logic [PROD_W-1:0] product_s;

    // Operand load muxes and product from the registered (pre-edge) operands
    always_comb begin
        x_d         = x_ld ? x_in : x_q;
        y_d         = y_ld ? y_in : y_q;
        operand_b_s = mult_sel ? x_q : y_q;
        product_s   = PROD_W'(x_q) * PROD_W'(operand_b_s);
    end

    // Operand registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= {DATA_W{1'b0}};
            y_q <= {DATA_W{1'b0}};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    mac_acc #(
        .PROD_W  (PROD_W),
        .ACC_W   (ACC_W),
        .N_TERMS (N_TERMS)
    ) u_acc (
        .clk_i       (clk),
        .rst_ni      (reset),
        .product_i   (product_s),
        .sum_ld_i    (sum_ld),
        .sum_clr_i   (sum_clr),
        .sum_o       (sum),
        .sum_valid_o (sum_valid),
        .term_cnt_o  (term_cnt),
        .done_o      (done),
        .ovf_o       (ovf)
    );

endmodule

// File: tb/tb_mac_datapath.sv
// Bench for mac_datapath: a 20-bit and an 8-bit accumulator instance share stimulus
// and are checked every cycle against an arithmetic model plus literal expectations.
module tb_mac_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x_in = 8'd0, y_in = 8'd0;
    logic       x_ld = 1'b0, y_ld = 1'b0, sum_ld = 1'b0, sum_clr = 1'b0, mult_sel = 1'b0;

    logic [19:0] sum0;  logic sv0, done0, ovf0;  logic [2:0] tc0;
    logic [7:0]  sum1;  logic sv1, done1, ovf1;  logic [2:0] tc1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: shared operands, per-instance accumulator view
    longint m_x, m_y;
    longint m_sum [2];
    int     m_cnt [2];
    bit     m_done[2], m_ovf[2], m_valid[2];
    int     accw  [2] = '{20, 8};

`ifdef MAC_SATURATE_EN
    localparam longint OVF_SUM1 = 255;
    localparam longint OVF_SUM2 = 255;
`else
    localparam longint OVF_SUM1 = 1;
    localparam longint OVF_SUM2 = 2;
`endif

    mac_datapath dut (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .x_ld(x_ld), .y_ld(y_ld),
        .sum_ld(sum_ld), .sum_clr(sum_clr), .mult_sel(mult_sel),
        .sum(sum0), .sum_valid(sv0), .term_cnt(tc0), .done(done0), .ovf(ovf0)
    );

    mac_datapath #(.ACC_W(8)) dut8 (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .x_ld(x_ld), .y_ld(y_ld),
        .sum_ld(sum_ld), .sum_clr(sum_clr), .mult_sel(mult_sel),
        .sum(sum1), .sum_valid(sv1), .term_cnt(tc1), .done(done1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0;
        m_y = 0;
        for (int k = 0; k < 2; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0; m_ovf[k] = 1'b0; m_valid[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        longint prod, t, lim;
        if (!reset) begin
            model_reset();
            return;
        end
        prod = m_x * (mult_sel ? m_x : m_y);
        for (int k = 0; k < 2; k++) begin
            lim = longint'(1) << accw[k];
            m_valid[k] = 1'b0;
            if (sum_clr) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0; m_ovf[k] = 1'b0;
            end else if (sum_ld && !m_done[k]) begin
                t = m_sum[k] + prod;
                if (t >= lim) begin
                    m_ovf[k] = 1'b1;
`ifdef MAC_SATURATE_EN
                    t = lim - 1;
`else
                    t = t % lim;
`endif
                end
                m_sum[k] = t;
                m_cnt[k]++;
                m_valid[k] = 1'b1;
                if (m_cnt[k] == 4) m_done[k] = 1'b1;
            end
        end
        if (x_ld) m_x = x_in;
        if (y_ld) m_y = y_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic xl, input logic yl, input logic sl, input logic sc,
                         input logic ms, input logic [7:0] xi, input logic [7:0] yi);
        x_ld = xl; y_ld = yl; sum_ld = sl; sum_clr = sc; mult_sel = ms; x_in = xi; y_in = yi;
    endtask

    task automatic load(input logic [7:0] xi, input logic [7:0] yi);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, xi, yi);
        tick();
    endtask

    task automatic accum();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tick();
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp20_sum",   64'(sum0),  64'(m_sum[0]));
            check("cmp20_valid", 64'(sv0),   64'(m_valid[0]));
            check("cmp20_cnt",   64'(tc0),   64'(m_cnt[0]));
            check("cmp20_done",  64'(done0), 64'(m_done[0]));
            check("cmp20_ovf",   64'(ovf0),  64'(m_ovf[0]));
            check("cmp8_sum",    64'(sum1),  64'(m_sum[1]));
            check("cmp8_valid",  64'(sv1),   64'(m_valid[1]));
            check("cmp8_cnt",    64'(tc1),   64'(m_cnt[1]));
            check("cmp8_done",   64'(done1), 64'(m_done[1]));
            check("cmp8_ovf",    64'(ovf1),  64'(m_ovf[1]));
        end
    end

    initial begin
        model_reset();
        #1;
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Reset held while strobes toggle
        for (int i = 0; i < 5; i++) begin
            drive(i[0], ~i[0], 1'b1, i[1], i[0], 8'(i * 37 + 5), 8'(i * 11 + 3));
            tick();
        end
        check("rst_sum",   64'(sum0),  64'd0);
        check("rst_cnt",   64'(tc0),   64'd0);
        check("rst_done",  64'(done0), 64'd0);
        check("rst_ovf",   64'(ovf0),  64'd0);
        check("rst_valid", 64'(sv0),   64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        reset = 1'b1;
        tick();

        // Four-term dot product
        load(8'd3, 8'd4);
        accum();
        check("dp1_sum",   64'(sum0), 64'd12);
        check("dp1_valid", 64'(sv0),  64'd1);
        check("dp1_cnt",   64'(tc0),  64'd1);
        load(8'd5, 8'd6);
        check("dp_valid_pulse", 64'(sv0), 64'd0);
        accum();
        check("dp2_sum", 64'(sum0), 64'd42);
        load(8'd1, 8'd2);
        accum();
        check("dp3_sum", 64'(sum0), 64'd44);
        check("dp3_done", 64'(done0), 64'd0);
        load(8'd7, 8'd1);
        accum();
        check("dp4_sum",  64'(sum0), 64'd51);
        check("dp4_done", 64'(done0), 64'd1);
        check("dp4_cnt",  64'(tc0),  64'd4);
        check("model_pin_sum", 64'(m_sum[0]), 64'd51);

        // Accumulate after done is ignored; clear beats accumulate
        accum();
        check("ign_sum",   64'(sum0), 64'd51);
        check("ign_cnt",   64'(tc0),  64'd4);
        check("ign_valid", 64'(sv0),  64'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        tick();
        check("clr_sum",   64'(sum0),  64'd0);
        check("clr_done",  64'(done0), 64'd0);
        check("clr_cnt",   64'(tc0),   64'd0);
        check("clr_valid", 64'(sv0),   64'd0);

        // Square mode with same-cycle x reload
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
        tick();
        check("sq_sum", 64'(sum0), 64'd81);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
        tick();
        check("sq_xnew_sum", 64'(sum0), 64'd85);

        // Overflow of the 8-bit accumulator
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick();
        load(8'd255, 8'd255);
        accum();
        check("ovf8_flag", 64'(ovf1), 64'd1);
        check("ovf8_sum",  64'(sum1), 64'(OVF_SUM1));
        check("ovf20_sum", 64'(sum0), 64'd65025);
        check("ovf20_flag", 64'(ovf0), 64'd0);
        accum();
        check("ovf8_sum2",  64'(sum1), 64'(OVF_SUM2));
        check("ovf8_flag2", 64'(ovf1), 64'd1);

        // Reset in the middle of a sequence
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick();
        load(8'd3, 8'd4);
        accum();
        accum();
        check("mid_sum_pre", 64'(sum0), 64'd24);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_sum", 64'(sum0), 64'd0);
        check("mid_rst_cnt", 64'(tc0),  64'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 8'd9);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        reset = 1'b1;
        tick();
        accum();
        check("post_rst_sum", 64'(sum0), 64'd0);
        check("post_rst_cnt", 64'(tc0),  64'd1);
        load(8'd2, 8'd3);
        accum();
        accum();
        check("post_rst_cnt3",  64'(tc0),   64'd3);
        check("post_rst_done3", 64'(done0), 64'd0);
        accum();
        check("post_rst_sum4",  64'(sum0),  64'd18);
        check("post_rst_done4", 64'(done0), 64'd1);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
